// File: rtl/uart_tx_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_framer_if
//  Description : Parallel-request / serial-line bundle for uart_tx_framer.
//                The master side presents payload, request and parity
//                controls. The slave side (the framer) returns the serial
//                line and the busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface : uart_tx_framer_if
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_framer
//  Description : UART transmit framer. Emits one serial bit per CLK edge:
//                start (0), DATA_WIDTH payload bits LSB first, an optional
//                parity bit, and stop (1). Back-to-back requests are accepted
//                at the edge that ends the stop bit.
//                The parity state and parity generation are built only when
//                the macro UART_TX_PARITY_EN is defined. Otherwise PAR_EN and
//                PAR_TYP are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8
) (
    input  wire              CLK,
    input  wire              RST,
    uart_tx_framer_if.slave  bus
);

    localparam int                CNT_W  = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_tx;
    logic                  r_busy;
    logic                  w_tx_next;
    logic                  w_capture;

`ifdef UART_TX_PARITY_EN
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  w_parity;

    // Even parity is the XOR of the payload; odd parity inverts it.
    assign w_parity = (^r_data) ^ r_par_typ;
`else
    // Parity controls stay on the port list but have no effect in this build.
    logic                  w_unused_par;
    assign w_unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

    assign w_cnt_inc  = r_bit_cnt + C_ONE;
    assign bus.TX_OUT = r_tx;
    assign bus.Busy   = r_busy;

    // Next state, next counter and the line value for the coming cycle.
    // TX_OUT and Busy are registered from the next state, which gives the
    // one-cycle request-to-start-bit latency.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_bit_cnt;
        w_tx_next    = 1'b1;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Data_Valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                w_state_next = S_DATA;
                w_cnt_next   = '0;
                w_tx_next    = r_data[0];
            end
            S_DATA: begin
                if (r_bit_cnt == C_LAST) begin
`ifdef UART_TX_PARITY_EN
                    if (r_par_en) begin
                        w_state_next = S_PARITY;
                        w_tx_next    = w_parity;
                    end else begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end
`else
                    w_state_next = S_STOP;
                    w_tx_next    = 1'b1;
`endif
                end else begin
                    w_cnt_next = w_cnt_inc;
                    w_tx_next  = r_data[w_cnt_inc];
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_state_next = S_STOP;
                w_tx_next    = 1'b1;
            end
`endif
            S_STOP: begin
                if (bus.Data_Valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end else begin
                    w_state_next = S_IDLE;
                    w_tx_next    = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // State, bit counter and registered line outputs; reset aborts any frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            r_tx      <= w_tx_next;
            r_busy    <= (w_state_next != S_IDLE);
        end
    end

    // Payload and parity controls are frozen at acceptance so later input
    // changes cannot disturb the frame on the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data    <= '0;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
`endif
        end else if (w_capture) begin
            r_data    <= bus.P_DATA;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= bus.PAR_EN;
            r_par_typ <= bus.PAR_TYP;
`endif
        end
    end

endmodule : uart_tx_framer
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_framer
//  Description : Self-checking bench for uart_tx_framer. Expected frames are
//                built as whole bit strings {stop, [parity], data, start}
//                and compared bit by bit against the serial line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_framer;

    localparam int DW = 8;

    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;

    uart_tx_framer_if #(.DATA_WIDTH(DW)) u_if ();

    uart_tx_framer #(.DATA_WIDTH(DW)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: the full serial frame, bit 0 first on the line.
    function automatic logic [15:0] model_frame(input logic [DW-1:0] d,
                                                input logic pe, input logic pt,
                                                output int len);
        logic eff_pe;
`ifdef UART_TX_PARITY_EN
        eff_pe = pe;
`else
        eff_pe = 1'b0;
        if (pe | pt) eff_pe = 1'b0;
`endif
        if (eff_pe) begin
            len = DW + 3;
            return 16'({1'b1, (^d) ^ pt, d, 1'b0});
        end
        len = DW + 2;
        return 16'({1'b1, d, 1'b0});
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request in the current cycle (idle or stop cycle) and check
    // every bit of the resulting frame. Returns inside the stop cycle with
    // Data_Valid low. noise: 0 quiet, 1 request 0x33 during the frame,
    // 2 random input churn during the frame.
    task automatic frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                         input int noise, input string name);
        logic [15:0] exp;
        int          len;
        exp = model_frame(d, pe, pt, len);
        u_if.P_DATA     = d;
        u_if.PAR_EN     = pe;
        u_if.PAR_TYP    = pt;
        u_if.Data_Valid = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("%s bit%0d", name, i), 16'(u_if.TX_OUT), 16'(exp[i]));
            chk($sformatf("%s busy%0d", name, i), 16'(u_if.Busy), 16'd1);
            u_if.Data_Valid = 1'b0;
            if (i < len - 1) begin
                if (noise == 1 && i >= 1) begin
                    u_if.P_DATA     = 8'h33;
                    u_if.Data_Valid = 1'b1;
                end else if (noise == 2) begin
                    u_if.P_DATA     = DW'($urandom);
                    u_if.PAR_EN     = 1'($urandom);
                    u_if.PAR_TYP    = 1'($urandom);
                    u_if.Data_Valid = 1'($urandom);
                end
            end
        end
    endtask

    task automatic idle_cycle(input string name);
        @(posedge CLK); #1;
        chk($sformatf("%s tx", name), 16'(u_if.TX_OUT), 16'd1);
        chk($sformatf("%s busy", name), 16'(u_if.Busy), 16'd0);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        RST             = 1'b0;
        u_if.P_DATA     = '0;
        u_if.Data_Valid = 1'b0;
        u_if.PAR_EN     = 1'b0;
        u_if.PAR_TYP    = 1'b0;

        // Reset state
        #12;
        chk("reset tx", 16'(u_if.TX_OUT), 16'd1);
        chk("reset busy", 16'(u_if.Busy), 16'd0);
        u_if.Data_Valid = 1'b1;
        @(posedge CLK); #1;
        chk("reset hold tx", 16'(u_if.TX_OUT), 16'd1);
        chk("reset hold busy", 16'(u_if.Busy), 16'd0);
        u_if.Data_Valid = 1'b0;
        RST = 1'b1;
        idle_cycle("idle0");
        idle_cycle("idle1");

        // Basic frame, then parity variants
        frame(8'hA5, 1'b0, 1'b0, 0, "basic");
        idle_cycle("basic end");
        frame(8'hA5, 1'b1, 1'b0, 0, "even");
        idle_cycle("even end");
        frame(8'hA5, 1'b1, 1'b1, 0, "odd");
        idle_cycle("odd end");

        // Back-to-back: second request presented in the stop cycle
        frame(8'h0F, 1'b0, 1'b0, 0, "b2b first");
        frame(8'hF0, 1'b0, 1'b0, 0, "b2b second");
        idle_cycle("b2b end");

        // Request during a frame must be ignored
        frame(8'h55, 1'b0, 1'b0, 1, "ignored");
        idle_cycle("ignored end");
        idle_cycle("ignored end2");

        // Reset in the middle of bit 3 (line index 4)
        u_if.P_DATA     = 8'h55;
        u_if.Data_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            u_if.Data_Valid = 1'b0;
        end
        chk("pre-abort busy", 16'(u_if.Busy), 16'd1);
        #2 RST = 1'b0;
        #1;
        chk("abort tx", 16'(u_if.TX_OUT), 16'd1);
        chk("abort busy", 16'(u_if.Busy), 16'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        idle_cycle("post-abort");
        frame(8'h81, 1'b0, 1'b0, 0, "after reset");
        idle_cycle("after reset end");

        // Randomized frames with input churn, random chaining and gaps
        for (int n = 0; n < 24; n++) begin
            frame(DW'($urandom), 1'($urandom), 1'($urandom), 2, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                    idle_cycle($sformatf("rnd%0d gap", n));
            end
        end
        idle_cycle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_tx_framer
`default_nettype wire

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of payload bits per frame (legal range 5..9).
REQ-002 Port CLK, input, 1 bit, SHALL be the bit-rate clock; one serial bit is emitted per rising edge.
REQ-003 Port RST, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port P_DATA, input, DATA_WIDTH bits, SHALL carry the parallel payload.
REQ-005 Port Data_Valid, input, 1 bit, SHALL request transmission of P_DATA.
REQ-006 Port PAR_EN, input, 1 bit, SHALL enable the parity bit (1 = parity bit present).
REQ-007 Port PAR_TYP, input, 1 bit, SHALL select the parity type (0 = even, 1 = odd).
REQ-008 Port TX_OUT, output, 1 bit, SHALL be the registered serial line, idle high.
REQ-009 Port Busy, output, 1 bit, SHALL be registered and high while a frame is on the line.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE with Data_Valid=1 at a rising edge, the block SHALL capture P_DATA, PAR_EN and PAR_TYP into internal registers and enter START.
REQ-012 Frame timing: TX_OUT=0 (start bit) and Busy=1 SHALL appear in the cycle after the edge that accepted Data_Valid, so latency is 1 cycle.
REQ-013 DATA SHALL emit the captured bits LSB first, one per cycle, using a bit counter of width clog2(DATA_WIDTH) that resets to 0 on entry to DATA.
REQ-014 After bit DATA_WIDTH-1 the FSM SHALL enter PARITY if the captured PAR_EN=1, otherwise STOP.
REQ-015 The parity bit SHALL be the XOR of the captured data bits for even parity, or its inverse for odd parity.
REQ-016 STOP SHALL drive TX_OUT=1 for exactly one cycle.
REQ-017 Frame length SHALL be 2+DATA_WIDTH cycles without parity and 3+DATA_WIDTH cycles with parity.
REQ-018 Back-to-back: Data_Valid=1 sampled at the edge that ends STOP SHALL capture new data and go directly to START; Busy stays high and no idle cycle is inserted.
REQ-019 Data_Valid sampled in START, DATA or PARITY SHALL be ignored, and no input change SHALL alter a frame in progress.
REQ-020 Busy SHALL fall to 0 in the first IDLE cycle after STOP when no back-to-back request is present.
REQ-021 In IDLE, TX_OUT SHALL be held at 1.

Reset
REQ-022 While RST=0, the block SHALL hold state=IDLE, TX_OUT=1, Busy=0, bit counter=0 and all capture registers at 0, asynchronously.
REQ-023 Assertion of RST mid-frame SHALL abort the frame immediately; after release, the block SHALL wait in IDLE for a new Data_Valid.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, the block SHALL include the PARITY state and parity generation as specified above.
REQ-025 Without UART_TX_PARITY_EN, ports PAR_EN and PAR_TYP SHALL remain present but be ignored, the PARITY state and parity logic SHALL be omitted, and every frame SHALL be 2+DATA_WIDTH cycles.

Verification
REQ-026 Basic frame: DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 and Busy high for exactly 10 cycles.
REQ-027 Even parity: 0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, frame 11 cycles; with PAR_TYP=1 -> parity bit 1.
REQ-028 Back-to-back: 0x0F then 0xF0, with Data_Valid held through the STOP cycle -> second start bit immediately follows the first stop bit, and Busy never drops.
REQ-029 Ignored request: Data_Valid pulsed with 0x33 during DATA of frame 0x55 -> only 0x55 is sent, and the line is idle afterward.
REQ-030 Reset mid-frame: RST=0 during bit 3 -> TX_OUT=1 and Busy=0 immediately; after release, a new 0x81 request produces a complete, correct frame.
REQ-031 Macro off: UART_TX_PARITY_EN undefined, PAR_EN=1, data 0xA5 -> 10-cycle frame with no parity bit.
